adc_moving_average: RTL and testbench
=====================================

// Module: adc_moving_average
// PURPOSE
//  Boxcar moving-average filter placed directly downstream of the PWM ADC front end.
//  Consumes the raw 16-bit conversion result and its data-ready strobe.
//  Averages the last 2**LOG2_N conversions.
//  Presents a smoothed 16-bit result with a one-cycle valid pulse for display/UART stages.
// PARAMETERS
//  DATA_W  16  width of input samples and averaged output
//  LOG2_N  3   log2 of window depth; window N = 2**LOG2_N (legal 1..6)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       synchronous, active-low reset (0 = reset)
//  clear      in   1       synchronous flush of window; same effect as reset, no port glitch
//  in_ready   in   1       ADC data-ready; may be a pulse or held high, rising edge = new sample
//  in_data    in   DATA_W  raw ADC conversion result, sampled on in_ready rising edge
//  avg_valid  out  1       one-cycle pulse: avg_out updated
//  avg_out    out  DATA_W  floor(sum of last N samples / N)
//  win_full   out  1       1 once N samples accumulated since reset/clear
// BEHAVIOUR
//  - Reset (reset==0 at clk edge) and clear:
//    - avg_valid=0, avg_out=0, win_full=0, running sum=0, write pointer=0, fill count=0.
//    - Edge-detect register cleared to 0, so an in_ready already high counts as a new edge.
//    - Buffer contents don't care; oldest value is treated as 0 while filling.
//  - Reset dominates clear; clear dominates a same-cycle sample accept (sample discarded).
//  - Sample accept: in_ready==1 and in_ready_q==0, where in_ready_q is the in_ready registered last cycle.
//    - A level held high yields exactly one accept.
//    - Back-to-back pulses separated by one low cycle are each accepted.
//  - Storage: circular buffer of N x DATA_W registers with LOG2_N-bit write pointer.
//    - Pointer wraps N-1 -> 0.
//    - The slot at the pointer holds the oldest sample.
//  - Running sum width DATA_W+LOG2_N; never overflows.
//    - On accept: sum <= sum + in_data - oldest.
//    - oldest = buf[wr_ptr] in RUN, 0 in FILL.
//    - Then buf[wr_ptr] <= in_data and wr_ptr++.
//  - FSM states:
//    - FILL (after reset/clear): each accept increments fill count. The accept that brings the count to N moves to RUN.
//    - RUN: the window slides; stays in RUN until reset/clear.
//  - Output, latency 1 cycle after the accept edge:
//    - avg_out <= sum_next >> LOG2_N (truncating).
//    - avg_valid pulses 1 cycle in both FILL and RUN.
//    - In FILL, avg_out is the partial sum / N (ramps up; not yet a true mean).
//  - win_full rises with the first avg_valid whose sum covers N samples and stays 1 in RUN.
//  - avg_out holds its value between pulses; no other output changes without an accept.
//  - All-ones input: sum max = N*(2**DATA_W-1), avg_out = 16'hFFFF exactly; no wrap.
// TESTING (N=4, LOG2_N=2)
//  - Reset: hold reset=0 3 cycles with in_ready toggling -> avg_valid never 1; avg_out=0; win_full=0.
//  - Fill: pulse samples 100,200,300,400 -> avg_out 25,75,150,250; each avg_valid 1 cycle after its edge.
//    - win_full rises with the 4th pulse.
//  - Slide/wrap: continue with 500,600 -> avg_out 350,450.
//    - After 8 total samples of 1000, avg_out=1000 (pointer wrapped twice).
//  - Level-held ready: hold in_ready=1 for 20 cycles, in_data=16'h0040 -> exactly one avg_valid pulse.
//    - Drop for 1 cycle, raise again -> a second pulse.
//  - Saturation: 4 samples of 16'hFFFF -> avg_out=16'hFFFF with no wrap.
//    - Then 4 samples of 0 -> 16'hBFFF, 16'h7FFF, 16'h3FFF, 0.
//  - Clear mid-operation: in RUN, assert clear in the same cycle as an in_ready edge.
//    - Sample is discarded, win_full=0, avg_out=0.
//    - Next sample 800 -> avg_out=200 (back in FILL).

Source files
------------

// File: rtl/adc_moving_average.sv
// rtl/adc_moving_average.sv - boxcar moving average over the last 2**LOG2_N ADC conversions
module adc_moving_average #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              win_full
);

  localparam int N     = 2 ** LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;

  typedef enum logic {FILL, RUN} state_t;

  state_t              state_q, state_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG2_N-1:0]   fill_cnt_q, fill_cnt_d;
  logic                in_ready_q;
  logic                avg_valid_q, avg_valid_d;
  logic [DATA_W-1:0]   avg_out_q, avg_out_d;
  logic                win_full_q, win_full_d;
  logic [DATA_W-1:0]   buf_q [N];
  logic                accept;
  logic [DATA_W-1:0]   oldest;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    avg_valid_d = 1'b0;
    avg_out_d   = avg_out_q;
    win_full_d  = win_full_q;
    accept      = in_ready & ~in_ready_q;
    // While filling, the slot under the pointer holds stale data; treat it as zero.
    oldest      = (state_q == RUN) ? buf_q[wr_ptr_q] : '0;

    if (accept) begin
      sum_d       = sum_q + SUM_W'(in_data) - SUM_W'(oldest);
      wr_ptr_d    = wr_ptr_q + LOG2_N'(1);
      avg_valid_d = 1'b1;
      avg_out_d   = DATA_W'(sum_d >> LOG2_N);
      if (state_q == FILL) begin
        fill_cnt_d = fill_cnt_q + LOG2_N'(1);
        if (fill_cnt_q == LOG2_N'(N - 1)) begin
          state_d    = RUN;
          win_full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q     <= FILL;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_out_q   <= '0;
      win_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      in_ready_q  <= in_ready;
      avg_valid_q <= avg_valid_d;
      avg_out_q   <= avg_out_d;
      win_full_q  <= win_full_d;
    end
  end

  // Sample storage needs no reset: FILL never reads it before overwriting.
  always_ff @(posedge clk) begin
    if (reset && !clear && accept) begin
      buf_q[wr_ptr_q] <= in_data;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_out   = avg_out_q;
  assign win_full  = win_full_q;

endmodule

// File: tb/tb_adc_moving_average.sv
// tb/tb_adc_moving_average.sv - table, directed and random checks of adc_moving_average (N=4)
module tb_adc_moving_average;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 2;
  localparam int N      = 4;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              avg_valid;
  logic [DATA_W-1:0] avg_out;
  logic              win_full;

  int checks = 0;
  int errors = 0;

  adc_moving_average #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .avg_valid (avg_valid),
    .avg_out   (avg_out),
    .win_full  (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a queue of the most recent samples, averaged with plain arithmetic.
  int   win_q[$];
  logic m_prev;
  logic exp_valid;
  int   exp_avg;
  logic exp_full;

  typedef struct {
    logic        rst;
    logic        clr;
    logic        rdy;
    logic [15:0] data;
    logic        ev;
    logic [15:0] eavg;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic rdy, input logic [15:0] d);
    int sum;
    if (!r || c) begin
      win_q.delete();
      m_prev    = 1'b0;
      exp_valid = 1'b0;
      exp_avg   = 0;
      exp_full  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (rdy && !m_prev) begin
        win_q.push_back(int'(d));
        if (win_q.size() > N) void'(win_q.pop_front());
        sum = 0;
        foreach (win_q[i]) sum += win_q[i];
        exp_avg   = sum / N;
        exp_valid = 1'b1;
        if (win_q.size() == N) exp_full = 1'b1;
      end
      m_prev = rdy;
    end
  endtask

  // Apply inputs for one clock, then compare every output with the model.
  task automatic cycle(input logic r, input logic c, input logic rdy, input logic [15:0] d);
    reset    = r;
    clear    = c;
    in_ready = rdy;
    in_data  = d;
    @(posedge clk);
    #1;
    model_step(r, c, rdy, d);
    check("model_valid", int'(avg_valid), int'(exp_valid));
    check("model_avg",   int'(avg_out),   exp_avg);
    check("model_full",  int'(win_full),  int'(exp_full));
  endtask

  task automatic pulse(input logic [15:0] d);
    cycle(1'b1, 1'b0, 1'b1, d);
    cycle(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    int pulses;
    logic [15:0] sat_exp [4];

    reset = 1'b0; clear = 1'b0; in_ready = 1'b0; in_data = '0;
    win_q.delete(); m_prev = 1'b0; exp_valid = 1'b0; exp_avg = 0; exp_full = 1'b0;

    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd100, 1'b1, 16'd25,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd25,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd200, 1'b1, 16'd75,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd75,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd300, 1'b1, 16'd150, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd150, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd400, 1'b1, 16'd250, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd250, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd500, 1'b1, 16'd350, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd350, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'd600, 1'b1, 16'd450, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd450, 1'b1});

    // Reset held three cycles while in_ready toggles.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, (i % 2 == 0), 16'd1234);
      check("reset_valid", int'(avg_valid), 0);
      check("reset_avg",   int'(avg_out),   0);
      check("reset_full",  int'(win_full),  0);
    end
    cycle(1'b1, 1'b0, 1'b0, 16'd0);

    // Fill and slide from the vector table.
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].clr, vecs[i].rdy, vecs[i].data);
      check($sformatf("vec%0d_valid", i), int'(avg_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d_avg", i),   int'(avg_out),   int'(vecs[i].eavg));
      check($sformatf("vec%0d_full", i),  int'(win_full),  int'(vecs[i].ef));
    end

    // Eight samples of 1000 wrap the pointer twice.
    for (int i = 0; i < 8; i++) pulse(16'd1000);
    check("wrap_avg", int'(avg_out), 1000);

    // Level-held ready gives one accept; a one-cycle drop re-arms it.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'h0040);
      pulses += int'(avg_valid);
    end
    check("level_pulses", pulses, 1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0040);
    pulses += int'(avg_valid);
    cycle(1'b1, 1'b0, 1'b1, 16'h0040);
    pulses += int'(avg_valid);
    check("rearm_pulses", pulses, 2);
    cycle(1'b1, 1'b0, 1'b0, 16'h0040);

    // Saturation and ramp-down.
    for (int i = 0; i < 4; i++) pulse(16'hFFFF);
    check("sat_avg", int'(avg_out), 32'hFFFF);
    check("sat_full", int'(win_full), 1);
    sat_exp[0] = 16'hBFFF; sat_exp[1] = 16'h7FFF; sat_exp[2] = 16'h3FFF; sat_exp[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      pulse(16'h0000);
      check($sformatf("ramp%0d_avg", i), int'(avg_out), int'(sat_exp[i]));
    end

    // Clear coincident with an accept edge discards the sample.
    cycle(1'b1, 1'b1, 1'b1, 16'd999);
    check("clear_valid", int'(avg_valid), 0);
    check("clear_full",  int'(win_full),  0);
    check("clear_avg",   int'(avg_out),   0);
    cycle(1'b1, 1'b0, 1'b0, 16'd0);
    check("clear_quiet", int'(avg_valid), 0);
    pulse(16'd800);
    check("postclear_avg",  int'(avg_out),  200);
    check("postclear_full", int'(win_full), 0);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 2000; i++) begin
      logic r, c, rdy;
      logic [15:0] d;
      r   = ($urandom_range(0, 99) != 0);
      c   = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 2) != 0) ? in_ready : ~in_ready;
      d   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(r, c, rdy, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
